// File: rtl/enc_gray_arbiter_if.sv
// Request/response bundle for the shared binary-to-Gray encoder slot.
interface enc_gray_arbiter_if #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 10,
  parameter int unsigned IDW   = (NREQ > 1) ? $clog2(NREQ) : 1
) ();

  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_bin;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [WIDTH-1:0]      rsp_gray;
  logic [IDW-1:0]        rsp_id;
  logic                  busy;

  // Requester/consumer side.
  modport master (
    output req_valid, req_bin, rsp_ready,
    input  req_ready, rsp_valid, rsp_gray, rsp_id, busy
  );

  // Encoder side.
  modport slave (
    input  req_valid, req_bin, rsp_ready,
    output req_ready, rsp_valid, rsp_gray, rsp_id, busy
  );

endinterface

// File: rtl/enc_gray_arbiter.sv
// Round-robin arbiter sharing one registered binary-to-Gray stage among NREQ requesters.
module enc_gray_arbiter #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 10,
  parameter int unsigned IDW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input logic               clk,
  input logic               rst,
  enc_gray_arbiter_if.slave bus
);

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } slot_e;

  slot_e            state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [WIDTH-1:0] gray_q, gray_d;

  logic [IDW-1:0]   idx;
  logic [IDW-1:0]   winner;
  logic             found;
  logic             slot_free;
  logic             accept;
  logic [WIDTH-1:0] sel_bin;
  logic [NREQ-1:0]  grant;
  logic [IDW-1:0]   ptr_next;

  function automatic logic [WIDTH-1:0] to_gray(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // First valid requester at or above the pointer, wrapping around.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = IDW'((32'(ptr_q) + k) % NREQ);
      if (!found && bus.req_valid[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  // Slot can take a new operand when empty or draining this cycle.
  assign slot_free = (state_q == S_EMPTY) || bus.rsp_ready;
  assign accept    = found && slot_free;
  assign ptr_next  = (winner == IDW'(NREQ - 1)) ? '0 : winner + IDW'(1);

  // Winner's operand mux and one-hot grant.
  always_comb begin
    sel_bin = '0;
    grant   = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (winner == IDW'(i)) begin
        sel_bin  = bus.req_bin[i*WIDTH +: WIDTH];
        grant[i] = accept;
      end
    end
  end

  // Next-state: accept loads the slot, otherwise a drain empties it.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gray_d  = gray_q;
    id_d    = id_q;
    if (accept) begin
      state_d = S_FULL;
      gray_d  = to_gray(sel_bin);
      id_d    = winner;
      ptr_d   = ptr_next;
    end else if ((state_q == S_FULL) && bus.rsp_ready) begin
      state_d = S_EMPTY;
    end
  end

  // Slot and pointer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_EMPTY;
      ptr_q   <= '0;
      gray_q  <= '0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gray_q  <= gray_d;
      id_q    <= id_d;
    end
  end

  // Grants are held off while reset is asserted even though the slot reads empty.
  assign bus.req_ready = rst ? '0 : grant;
  assign bus.rsp_valid = (state_q == S_FULL);
  assign bus.busy      = (state_q == S_FULL);
  assign bus.rsp_gray  = gray_q;
  assign bus.rsp_id    = id_q;

endmodule

// File: tb/tb_enc_gray_arbiter.sv
// Directed scoreboard bench for enc_gray_arbiter (NREQ=4, WIDTH=10).
module tb_enc_gray_arbiter;

  localparam int unsigned NREQ  = 4;
  localparam int unsigned WIDTH = 10;
  localparam int unsigned IDW   = 2;

  typedef struct packed {
    logic [IDW-1:0]   id;
    logic [WIDTH-1:0] gray;
  } exp_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  exp_t exp_q[$];

  enc_gray_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) bus ();

  enc_gray_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_bin(input int i, input logic [WIDTH-1:0] v);
    bus.req_bin[i*WIDTH +: WIDTH] = v;
  endtask

  // Check the grant for this cycle, queue the expected response, advance one clock.
  task automatic grant_cycle(input int id, input logic [WIDTH-1:0] gray, input bit push);
    exp_t e;
    logic [NREQ-1:0] oh;
    @(negedge clk);
    oh = '0;
    oh[id] = 1'b1;
    chk("req_ready", 32'(bus.req_ready), 32'(oh));
    if (push) begin
      e.id   = IDW'(id);
      e.gray = gray;
      exp_q.push_back(e);
    end
    step();
  endtask

  // Monitor: pop and compare whenever a response is taken downstream.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      chk("busy_eq_valid", 32'(bus.busy), 32'(bus.rsp_valid));
      chk("ready_onehot", 32'($countones(bus.req_ready) <= 1), 32'd1);
      if (bus.rsp_valid && bus.rsp_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_rsp", 32'(bus.rsp_id), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_id", 32'(bus.rsp_id), 32'(e.id));
          chk("rsp_gray", 32'(bus.rsp_gray), 32'(e.gray));
        end
      end
    end
  end

  initial begin
    logic [WIDTH-1:0] corner_bin  [4];
    logic [WIDTH-1:0] corner_gray [4];
    int               rr_id       [6];
    logic [WIDTH-1:0] rr_gray     [4];

    corner_bin  = '{10'h000, 10'h001, 10'h200, 10'h3FF};
    corner_gray = '{10'h000, 10'h001, 10'h300, 10'h200};
    rr_id       = '{0, 1, 2, 3, 0, 1};
    rr_gray     = '{10'h088, 10'h1FF, 10'h3F7, 10'h222};

    n_checks      = 0;
    n_fail        = 0;
    rst           = 1'b1;
    bus.req_valid = '1;
    bus.req_bin   = '0;
    bus.rsp_ready = 1'b0;

    // Reset values, with requests pending
    @(negedge clk);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_gray", 32'(bus.rsp_gray), 32'd0);
    chk("rst_rsp_id", 32'(bus.rsp_id), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    bus.req_valid = '0;
    step();
    rst = 1'b0;
    step();

    // Single request from requester 2
    bus.rsp_ready = 1'b1;
    set_bin(2, 10'h2A5);
    bus.req_valid = 4'b0100;
    grant_cycle(2, 10'h3F7, 1'b1);
    bus.req_valid = '0;
    step();
    @(negedge clk);
    chk("drain_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("drain_gray_hold", 32'(bus.rsp_gray), 32'h3F7);
    chk("drain_id_hold", 32'(bus.rsp_id), 32'd2);
    step();

    // Conversion corners through requester 0, back to back
    bus.req_valid = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      set_bin(0, corner_bin[i]);
      grant_cycle(0, corner_gray[i], 1'b1);
    end
    bus.req_valid = '0;
    step();
    step();

    // Round robin from reset with all requesters valid
    rst = 1'b1;
    step();
    rst = 1'b0;
    set_bin(0, 10'h0F0);
    set_bin(1, 10'h155);
    set_bin(2, 10'h2A5);
    set_bin(3, 10'h3C3);
    bus.req_valid = 4'b1111;
    for (int i = 0; i < 6; i++) begin
      grant_cycle(rr_id[i], rr_gray[rr_id[i]], 1'b1);
    end
    bus.req_valid = '0;
    step();
    step();

    // Backpressure: hold response for 5 cycles, then drain and accept together
    bus.req_valid = 4'b0001;
    grant_cycle(0, 10'h088, 1'b1);
    bus.req_valid = 4'b0010;
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_req_ready", 32'(bus.req_ready), 32'd0);
      chk("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      chk("bp_rsp_gray", 32'(bus.rsp_gray), 32'h088);
      chk("bp_rsp_id", 32'(bus.rsp_id), 32'd0);
      step();
    end
    bus.rsp_ready = 1'b1;
    grant_cycle(1, 10'h1FF, 1'b1);
    bus.req_valid = '0;
    step();
    step();

    // Sparse round robin with pointer at 2
    @(negedge clk);
    chk("idle_req_ready", 32'(bus.req_ready), 32'd0);
    step();
    bus.req_valid = 4'b1010;
    grant_cycle(3, 10'h222, 1'b1);
    grant_cycle(1, 10'h1FF, 1'b1);
    grant_cycle(3, 10'h222, 1'b1);
    bus.req_valid = '0;
    step();
    step();

    // Asynchronous reset while a response is pending
    bus.rsp_ready = 1'b0;
    bus.req_valid = 4'b0001;
    grant_cycle(0, 10'h088, 1'b0);
    bus.req_valid = '0;
    #1;
    chk("pre_rst_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("arst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("arst_rsp_gray", 32'(bus.rsp_gray), 32'd0);
    chk("arst_rsp_id", 32'(bus.rsp_id), 32'd0);
    chk("arst_busy", 32'(bus.busy), 32'd0);
    chk("arst_req_ready", 32'(bus.req_ready), 32'd0);
    step();
    rst = 1'b0;
    bus.rsp_ready = 1'b1;
    bus.req_valid = 4'b1111;
    grant_cycle(0, 10'h088, 1'b1);
    bus.req_valid = '0;
    step();
    step();
    step();

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/enc_gray_arbiter.md
Name: enc_gray_arbiter

Overview:
- Shares one registered binary-to-Gray conversion stage between NREQ requesters.
- Each requester presents a WIDTH-bit binary value with a valid/ready handshake. A round-robin arbiter grants one requester per cycle.
- The Gray result is returned on a single output channel tagged with the requester id, with valid/ready backpressure.
- Sits in front of the pointer/counter encoders so several clock-domain-crossing pointers reuse one encoder slot.

Parameters:
- NREQ, 4, number of requesters (2..16).
- WIDTH, 10, binary/Gray word width.
- IDW, clog2(NREQ), width of the requester id.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  asynchronous active-high reset.
- req_valid  input  NREQ  per-requester request valid.
- req_ready  output  NREQ  per-requester accept. At most one bit high per cycle.
- req_bin  input  NREQ*WIDTH  packed binary operands. Requester i occupies bits [i*WIDTH +: WIDTH].
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  downstream accept.
- rsp_gray  output  WIDTH  Gray code of the accepted operand.
- rsp_id  output  IDW  index of the requester that produced rsp_gray.
- busy  output  1  high while rsp_valid is high.

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is asynchronous and active-high. While rst is high:
  - rsp_valid=0, rsp_gray=0, rsp_id=0, busy=0, req_ready=0.
  - Round-robin pointer = 0, so requester 0 has first priority after reset.
- Conversion: gray[WIDTH-1] = bin[WIDTH-1]; gray[k] = bin[k+1] ^ bin[k] for k < WIDTH-1.
- Output slot is free when rsp_valid==0 or (rsp_valid && rsp_ready). When the slot is free, a new accept may occur in the same cycle the old response drains.
- Arbitration (combinational):
  - Among asserted req_valid bits, search from the pointer upward with wrap-around. The first set bit is the winner.
  - req_ready[winner] = slot free. All other req_ready bits = 0.
  - req_ready never depends on req_valid of the same requester beyond the winner selection.
- Accept: a transfer on requester i occurs when req_valid[i] && req_ready[i]. On that rising edge:
  - rsp_gray <= gray(req_bin[i]), rsp_id <= i, rsp_valid <= 1.
  - Pointer <= (i+1) mod NREQ.
- Latency: exactly 1 cycle from accept edge to rsp_valid. Throughput: 1 result per cycle when rsp_ready is held high.
- Drain without accept: rsp_valid && rsp_ready with no new accept -> rsp_valid <= 0. rsp_gray and rsp_id hold their last values.
- Backpressure: rsp_valid && !rsp_ready -> rsp_gray, rsp_id and rsp_valid hold stable, and all req_ready = 0.
- No valid requesters: no accept, pointer unchanged.
- Pointer update: changes only on an accept.
- Fairness: a continuously asserted requester is granted within NREQ accepts.
- Requester protocol: a requester keeps req_valid and req_bin stable until accepted. The block does not check this; the bench does.
- Reset mid-operation: any pending response is discarded, all outputs return to reset values immediately (asynchronous), and the pointer returns to 0.
- busy = rsp_valid.

Test Plan:
- Single request, NREQ=4/WIDTH=10: requester 2 sends bin=0x2A5 with rsp_ready=1 -> req_ready[2]=1 that cycle; next cycle rsp_valid=1, rsp_gray=0x3F7, rsp_id=2.
- Conversion corners through requester 0: 0x000->0x000, 0x001->0x001, 0x200->0x300, 0x3FF->0x200, each 1 cycle after accept.
- Round-robin: all four valid from reset with rsp_ready=1 -> accepts in order ids 0,1,2,3,0,1 on consecutive cycles; rsp_id follows one cycle later.
- Backpressure: accept id 0, then rsp_ready=0 for 5 cycles -> rsp_valid=1 and rsp_gray/rsp_id stable, all req_ready=0. When rsp_ready returns to 1, id 1 is accepted in the same cycle the old response drains.
- Sparse round-robin: only requesters 1 and 3 valid with pointer at 2 -> requester 3 is granted first, then 1, then 3.
- Async reset mid-stream: assert rst between clock edges while rsp_valid=1 -> rsp_valid=0, rsp_gray=0 immediately. After release, with all requesters valid, requester 0 is granted first.
